serial_frame_collector: RTL and testbench
=========================================

Name: serial_frame_collector

Overview:
- Consumes the 1-bit serial stream leaving the DFF_link_4 delay chain (its output_data), one bit per CLK.
- Hunts for a sync word, deserialises the DATA_WIDTH payload bits that follow (MSB first), and checks one trailing even-parity bit.
- Presents the recovered word in parallel with a one-cycle valid strobe to downstream logic.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 2..32.
- SYNC_WIDTH, 4, sync word length in bits; legal range 2..8.
- SYNC_PATTERN, 4'b1011, sync word, MSB received first; must not be all-zero.

Ports:
- CLK  input  1  processing clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- input_data  input  1  serial bit stream from the upstream DFF chain, sampled every rising CLK edge.
- output_data  output  DATA_WIDTH  last completed frame payload; holds until the next frame completes.
- data_valid  output  1  one-cycle strobe: a frame completed on this edge.
- parity_error  output  1  qualified by data_valid; 1 = parity check failed.
- frame_active  output  1  high while in COLLECT or PARITY.
- good_count  output  8  count of frames with correct parity; wraps 255 -> 0.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is asynchronous and active-high.
- Reset (async, immediate):
  - State -> HUNT; sync shift register, data shift register and bit counter cleared.
  - Outputs: output_data = 0, data_valid = 0, parity_error = 0, frame_active = 0, good_count = 0.
- FSM states: HUNT, COLLECT, PARITY.
- HUNT:
  - Each edge: sync_sr <= {sync_sr[SYNC_WIDTH-2:0], input_data}.
  - If the shifted value equals SYNC_PATTERN, the same edge moves to COLLECT and clears bit_cnt.
  - Detection is sliding and overlapping: the earliest match wins.
- COLLECT:
  - Each edge: data_sr <= {data_sr[DATA_WIDTH-2:0], input_data}; bit_cnt increments.
  - On the edge sampling payload bit DATA_WIDTH, move to PARITY.
  - Sync-like patterns inside the payload are ignored.
- PARITY (single edge): sample the parity bit p.
  - Even parity: error = (^data_sr) ^ p.
  - Register output_data <= data_sr; data_valid <= 1; parity_error <= error.
  - good_count increments only if error = 0.
  - Return to HUNT with sync_sr cleared to 0, so frame bits never form part of the next sync.
- Latency: data_valid goes high after edge SYNC_WIDTH+DATA_WIDTH+1, counting from the first sync-bit edge (edge 13 at defaults). It is low again after the following edge.
- parity_error is 0 whenever data_valid is 0.
- Back-to-back frames: the next sync may start on the edge after the parity edge. There is no minimum gap.
- frame_active is registered: it is 1 from the edge after the sync match through the parity edge, and 0 after that edge.
- bit_cnt width is $clog2(DATA_WIDTH+1). No wrap is possible, since it is cleared on entering COLLECT.
- Reset mid-frame: the partial frame is discarded. output_data and good_count also clear.
- Before the first upstream edges, input_data may be X. The design must not leave HUNT on X; the bench drives known values before the check window.

Decomposition:
- Shared package (collector_pkg):
  - state encoding constants ST_HUNT = 2'd0, ST_COLLECT = 2'd1, ST_PARITY = 2'd2;
  - default DATA_WIDTH, SYNC_WIDTH and SYNC_PATTERN constants.
- One sub-module, sync_detector:
  - Contains the SYNC_WIDTH shift register and comparator.
  - Ports: CLK, RST, enable, clear, input_data, match.
  - The top level holds the FSM, payload shifter, parity and counter.

Test Plan:
- Reset: hold RST = 1 while toggling input_data -> all outputs 0 and state HUNT throughout. Release between edges -> no spurious data_valid.
- Good frame: bits 1011, 10100101, parity 0 -> data_valid high for exactly one cycle, 13 edges after the first sync bit; output_data = 8'hA5, parity_error = 0, good_count = 1.
- Bad parity: bits 1011, 8'h3C, parity 1 -> data_valid = 1, parity_error = 1, output_data = 8'h3C, good_count unchanged.
- Overlapping sync in noise: 0,1,0,1,1,0,1,1 then 8'hFF, parity 0 -> match on bit index 4 (first 1011). The payload is the bits that follow; a 1011 sequence inside the payload does not retrigger. Expected output_data = {0,1,1, next 5 bits}, computed by the bench's reference model.
- Reset mid-frame: assert RST asynchronously after 3 payload bits -> outputs clear immediately without waiting for CLK. After release, a full 8'h5A frame is received correctly and good_count = 1.
- Stress: 256 back-to-back good frames with random payloads -> every payload matches in order, and good_count wraps to 0.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared types and default parameters for the serial frame collector.
package collector_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_SYNC_WIDTH = 4;
    localparam logic [DEF_SYNC_WIDTH-1:0] DEF_SYNC_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_frame_collector_if.sv
// Serial input and parallel frame outputs of the collector.
interface serial_frame_collector_if
    import collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  input_data;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  frame_active;
    logic [7:0]            good_count;

    modport master (
        output input_data,
        input  output_data, data_valid, parity_error, frame_active, good_count
    );

    modport slave (
        input  input_data,
        output output_data, data_valid, parity_error, frame_active, good_count
    );
endinterface

// File: rtl/sync_detector.sv
// Sliding sync-word detector; match reflects the value being shifted in this edge.
module sync_detector
    import collector_pkg::*;
#(
    parameter int unsigned SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic clear,
    input  logic input_data,
    output logic match
);
    logic [SYNC_WIDTH-1:0] sync_sr_q, sync_sr_d, shifted;

    always_comb begin
        shifted   = {sync_sr_q[SYNC_WIDTH-2:0], input_data};
        sync_sr_d = sync_sr_q;
        if (clear) begin
            sync_sr_d = '0;
        end else if (enable) begin
            sync_sr_d = shifted;
        end
        match = enable && (shifted == SYNC_PATTERN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_sr_q <= '0;
        end else begin
            sync_sr_q <= sync_sr_d;
        end
    end
endmodule

// File: rtl/serial_frame_collector.sv
// Hunts a sync word in a serial stream, deserialises the payload MSB first
// and checks a trailing even-parity bit.
module serial_frame_collector
    import collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
    input logic CLK,
    input logic RST,
    serial_frame_collector_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] output_data_q, output_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  frame_active_q, frame_active_d;
    logic [7:0]            good_count_q, good_count_d;
    logic                  sync_match;
    logic                  parity_err;

    sync_detector #(
        .SYNC_WIDTH   (SYNC_WIDTH),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (state_q == ST_HUNT),
        .clear      (state_q == ST_PARITY),
        .input_data (bus.input_data),
        .match      (sync_match)
    );

    always_comb begin
        state_d        = state_q;
        data_sr_d      = data_sr_q;
        bit_cnt_d      = bit_cnt_q;
        output_data_d  = output_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        good_count_d   = good_count_q;
        parity_err     = (^data_sr_q) ^ bus.input_data;

        case (state_q)
            ST_HUNT: begin
                if (sync_match) begin
                    state_d   = ST_COLLECT;
                    bit_cnt_d = '0;
                end
            end
            ST_COLLECT: begin
                data_sr_d = {data_sr_q[DATA_WIDTH-2:0], bus.input_data};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                output_data_d  = data_sr_q;
                data_valid_d   = 1'b1;
                parity_error_d = parity_err;
                if (!parity_err) begin
                    good_count_d = good_count_q + 8'd1;
                end
                state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase

        // Registered so it is high exactly while the FSM sits in COLLECT/PARITY
        frame_active_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_HUNT;
            data_sr_q      <= '0;
            bit_cnt_q      <= '0;
            output_data_q  <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_active_q <= 1'b0;
            good_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            data_sr_q      <= data_sr_d;
            bit_cnt_q      <= bit_cnt_d;
            output_data_q  <= output_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            frame_active_q <= frame_active_d;
            good_count_q   <= good_count_d;
        end
    end

    assign bus.output_data  = output_data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_active = frame_active_q;
    assign bus.good_count   = good_count_q;
endmodule

// File: tb/tb_serial_frame_collector.sv
// Randomized bench for serial_frame_collector against a stream-scanning reference model.
module tb_serial_frame_collector;
    import collector_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_frame_collector_if #(.DATA_WIDTH(DW)) bus ();

    serial_frame_collector #(
        .DATA_WIDTH   (DW),
        .SYNC_WIDTH   (SW),
        .SYNC_PATTERN (PAT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit [DW-1:0] m_word  = '0;
    bit [7:0]    m_count = '0;
    bit          stim[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_bits(input logic [31:0] v, input int unsigned nb);
        for (int unsigned b = nb; b > 0; b--) stim.push_back(v[b-1]);
    endfunction

    function automatic void push_frame(input logic [DW-1:0] w, input bit p);
        push_bits(32'(PAT), SW);
        push_bits(32'(w), DW);
        push_bits(32'(p), 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ":valid"},  32'(bus.data_valid),   32'd0);
        check_eq({tag, ":perr"},   32'(bus.parity_error), 32'd0);
        check_eq({tag, ":word"},   32'(bus.output_data),  32'd0);
        check_eq({tag, ":count"},  32'(bus.good_count),   32'd0);
        check_eq({tag, ":active"}, 32'(bus.frame_active), 32'd0);
    endtask

    // Scan the whole stream for frames first, then replay it cycle by cycle.
    task automatic run_stream(input string tag, input bit bits[$]);
        int          n = bits.size();
        bit          ev[];
        bit          act[];
        bit          err[];
        bit [DW-1:0] word[];
        bit [SW-1:0] win;
        int          i;
        ev = new[n]; act = new[n]; err = new[n]; word = new[n];
        win = '0;
        i = 0;
        while (i < n) begin
            win = {win[SW-2:0], bits[i]};
            if (win == PAT) begin
                for (int k = i; k <= i + int'(DW) && k < n; k++) act[k] = 1'b1;
                if (i + int'(DW) + 1 < n) begin
                    bit [DW-1:0] w;
                    w = '0;
                    for (int k = 1; k <= int'(DW); k++) w = (w << 1) | DW'(bits[i + k]);
                    ev[i + DW + 1]   = 1'b1;
                    word[i + DW + 1] = w;
                    err[i + DW + 1]  = (($countones(w) + int'(bits[i + DW + 1])) % 2) != 0;
                    win = '0;
                    i = i + int'(DW) + 2;
                end else begin
                    i = n;
                end
            end else begin
                i++;
            end
        end

        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.input_data = bits[k];
            @(posedge clk);
            #1;
            if (ev[k]) begin
                m_word = word[k];
                if (!err[k]) m_count = m_count + 8'd1;
            end
            check_eq({tag, ":valid"},  32'(bus.data_valid),   32'(ev[k]));
            check_eq({tag, ":perr"},   32'(bus.parity_error), ev[k] ? 32'(err[k]) : 32'd0);
            check_eq({tag, ":word"},   32'(bus.output_data),  32'(m_word));
            check_eq({tag, ":count"},  32'(bus.good_count),   32'(m_count));
            check_eq({tag, ":active"}, 32'(bus.frame_active), 32'(act[k]));
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [7:0]    rst_toggle;

        bus.input_data = 1'b0;
        #1 rst = 1'b1;

        // Reset held while feeding a sync-like pattern
        rst_toggle = 8'b1011_1011;
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            bus.input_data = rst_toggle[k];
            @(posedge clk);
            #1;
            check_idle_outputs("reset");
        end
        @(negedge clk);
        bus.input_data = 1'b0;
        #2 rst = 1'b0;

        for (int k = 0; k < 12; k++) stim.push_back(1'b0);
        run_stream("idle", stim);
        stim.delete();

        push_frame(8'hA5, 1'b0);
        run_stream("good", stim);
        stim.delete();
        check_eq("good_word",  32'(bus.output_data), 32'h0000_00A5);
        check_eq("good_count", 32'(bus.good_count),  32'd1);

        push_frame(8'h3C, 1'b1);
        run_stream("badpar", stim);
        stim.delete();
        check_eq("badpar_word",  32'(bus.output_data), 32'h0000_003C);
        check_eq("badpar_count", 32'(bus.good_count),  32'd1);

        push_bits(32'b0101_1011, 8);
        push_bits(32'hFF, 8);
        push_bits(32'd0, 1);
        push_bits(32'd0, SW);
        run_stream("overlap", stim);
        stim.delete();
        check_eq("overlap_word", 32'(bus.output_data), 32'h0000_007F);

        for (int k = 0; k < 160; k++) stim.push_back(bit'($urandom_range(0, 1)));
        push_bits(32'd0, DW + 1 + SW);
        run_stream("noise", stim);
        stim.delete();

        // Sync plus three payload bits of 5A, then an asynchronous reset mid-cycle
        push_bits(32'(PAT), SW);
        push_bits(32'b010, 3);
        run_stream("partial", stim);
        stim.delete();
        #2 rst = 1'b1;
        #1;
        m_word  = '0;
        m_count = '0;
        check_idle_outputs("midreset");
        @(negedge clk);
        #2 rst = 1'b0;
        push_frame(8'h5A, 1'b0);
        run_stream("after_reset", stim);
        stim.delete();
        check_eq("after_reset_word",  32'(bus.output_data), 32'h0000_005A);
        check_eq("after_reset_count", 32'(bus.good_count),  32'd1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        m_word  = '0;
        m_count = '0;
        check_idle_outputs("stress_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        w = '0;
        for (int f = 0; f < 256; f++) begin
            w = DW'($urandom);
            push_frame(w, bit'($countones(w) % 2));
        end
        run_stream("stress", stim);
        stim.delete();
        check_eq("stress_wrap", 32'(bus.good_count),  32'd0);
        check_eq("stress_last", 32'(bus.output_data), 32'(w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
